i2c_byte_engine: RTL
====================

Name: i2c_byte_engine

Overview:
- Protocol engine downstream of the I2C Wishbone register file.
- Consumes the register file's ctrl, tx and clk_div values and runs one single-byte I2C master transaction: START, address+R/W, one data byte, STOP.
- Returns rx and status to the register file and drives the SCL/SDA pads as open-drain.
- Fixed 7-bit target address per instance.

Parameters:
SLAVE_ADDRESS, 7'h50, 7-bit target address sent in the address byte.
CLK_DIV_W, 16, width of the quarter-bit prescaler ({clk_div_hi, clk_div_lo}).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
clk_div  in  CLK_DIV_W  quarter-bit period minus 1, in clk cycles
ctrl  in  8  [7]=EN, [1]=RW (1=read), [0]=GO; other bits ignored
tx  in  8  write data byte
rx  out  8  read data byte
status  out  8  [0]=BUSY, [1]=DONE, [2]=NACK; [7:3]=0
scl_i  in  1  SCL pad input (already synchronised)
scl_oe  out  1  1 = pull SCL low
sda_i  in  1  SDA pad input (already synchronised)
sda_oe  out  1  1 = pull SDA low
state_debug  out  4  current FSM state encoding
bit_counter_debug  out  3  current bit index

Behaviour:
- Reset:
  - scl_oe=0, sda_oe=0, rx=0, status=0.
  - FSM=IDLE, bit counter=7, prescaler=0, GO edge register=0.
- Reset mid-transaction releases both lines on the next clk edge; no STOP is generated.
- GO handling:
  - ctrl[0] is registered; a rising edge while state=IDLE and ctrl[7]=1 launches a transaction.
  - BUSY=1 and DONE=NACK=0 from the next cycle.
  - GO edges while busy are ignored.
  - RW and tx are sampled at launch.
- Prescaler:
  - A tick fires every clk_div+1 clk cycles.
  - clk_div=0 gives a tick every cycle.
  - The prescaler counts only while not IDLE and restarts at 0 on launch.
- Bit timing: each phase is 4 ticks, quarters q0..q3.
  - Data bit: q0 SCL low, SDA set up; q1 SCL released; q2 SDA sampled on entry; q3 SCL still high.
- FSM states:
  - IDLE: nothing in progress.
  - START: q0 both lines released; q1 SDA low; q2 hold; q3 SCL low.
  - ADDR: 8 bits, MSB first = {SLAVE_ADDRESS, RW}; bit counter runs 7 down to 0.
  - ADDR_ACK: SDA released; sample. SDA=1 sets NACK and goes to STOP; SDA=0 goes to DATA.
  - DATA, write: shifts tx MSB first.
  - DATA, read: SDA released; shifts sampled bits into a shadow register. rx updates only at the end of DATA_ACK.
  - DATA_ACK, write: slave ACK sampled; SDA=1 sets NACK.
  - DATA_ACK, read: master NACKs (SDA released).
  - STOP: q0 SCL low, SDA low; q1 SCL released; q2 hold; q3 SDA released.
  - DONE: one cycle; BUSY=0, DONE=1; then IDLE.
  - DONE and NACK hold until the next launch.
- Abort: ctrl[7] dropping to 0 mid-transaction means:
  - next cycle releases both lines and goes to IDLE;
  - BUSY=0, DONE=0, NACK unchanged.
- Transaction length: write or read = 4+36+36+4 = 80 ticks; address NACK = 4+36+4 = 44 ticks.
- Simultaneous reset and GO: reset wins.
- clk_div changes mid-transaction take effect at the next prescaler reload.

Optional Feature:
- I2C_CLK_STRETCH_EN defined: in q1/q2/q3, if scl_oe=0 and scl_i=0 (slave holding SCL low), the prescaler and FSM freeze until scl_i=1.
- Undefined: scl_i is ignored and timing is purely tick-based.

Decomposition:
- Package i2c_pkg holds:
  - state enum (IDLE=0, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE);
  - ctrl bit indices (CTRL_EN=7, CTRL_RW=1, CTRL_GO=0);
  - status bit indices (ST_BUSY=0, ST_DONE=1, ST_NACK=2).
- One sub-module, i2c_tick_gen: prescaler with clear/enable/freeze inputs and a tick output.

Test Plan:
- Write, ACKed: clk_div=4, ctrl=8'h81, tx=8'hA5, slave model ACKs.
  - SDA shows START, 1010000_0, ACK, 10100101, ACK, STOP.
  - DONE=1 and NACK=0 after 400±3 cycles; status=8'h02.
- Read: ctrl=8'h83, slave returns 8'h3C.
  - Address byte 8'hA1; master NACK in data ack slot.
  - rx=8'h3C, status=8'h02.
- Address NACK: no slave present, ctrl=8'h81.
  - STOP follows the address ack slot; no data byte.
  - status=8'h06 after 44*(clk_div+1) cycles.
- Abort: clear ctrl[7] during ADDR bit 3.
  - scl_oe=sda_oe=0 next cycle; state_debug=0; status=8'h00.
- Reset mid-DATA: rst for one cycle.
  - All outputs return to reset values; a new GO edge runs a full transaction normally.
- GO while BUSY: toggle ctrl[0] during DATA.
  - No effect; exactly one transaction completes.
  - With I2C_CLK_STRETCH_EN, slave holding SCL low for 50 cycles extends the transaction by 50 cycles.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and register bit indices for the I2C byte engine
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    START    = 4'd1,
    ADDR     = 4'd2,
    ADDR_ACK = 4'd3,
    DATA     = 4'd4,
    DATA_ACK = 4'd5,
    STOP     = 4'd6,
    DONE     = 4'd7
  } state_t;

  localparam int CTRL_EN = 7;
  localparam int CTRL_RW = 1;
  localparam int CTRL_GO = 0;

  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_NACK = 2;

endpackage

// File: rtl/i2c_tick_gen.sv
// rtl/i2c_tick_gen.sv - quarter-bit prescaler: one tick every div+1 enabled, unfrozen cycles
module i2c_tick_gen #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         freeze,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] cnt;

  // >= rather than == so a shrinking div mid-count reloads instead of wrapping
  assign tick = en && !freeze && (cnt >= div);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !freeze) begin
      cnt <= (cnt >= div) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_byte_engine.sv
// rtl/i2c_byte_engine.sv - single-byte I2C master (START, addr+RW, data, STOP), open-drain pads
// Define I2C_CLK_STRETCH_EN to let a slave hold SCL low and freeze the bit timing.
module i2c_byte_engine
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h50,
  parameter int         CLK_DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CLK_DIV_W-1:0] clk_div,
  input  logic [7:0]           ctrl,
  input  logic [7:0]           tx,
  output logic [7:0]           rx,
  output logic [7:0]           status,
  input  logic                 scl_i,
  output logic                 scl_oe,
  input  logic                 sda_i,
  output logic                 sda_oe,
  output logic [3:0]           state_debug,
  output logic [2:0]           bit_counter_debug
);

  state_t     state_q, state_d;
  logic [1:0] q_q;
  logic [2:0] bit_q;
  logic [7:0] shift_q, tx_q;
  logic       rw_q, go_q, samp_q, busy_q, done_q, nack_q;
  logic       tick, launch, abort, phase_end, freeze, active;
  logic       unused_inputs;

  assign unused_inputs = ^{ctrl[6:2], scl_i};

  assign active    = (state_q != IDLE) && (state_q != DONE);
  assign launch    = (state_q == IDLE) && ctrl[CTRL_EN] && ctrl[CTRL_GO] && !go_q;
  assign abort     = (state_q != IDLE) && !ctrl[CTRL_EN];
  assign phase_end = tick && (q_q == 2'd3);

`ifdef I2C_CLK_STRETCH_EN
  // SCL released by us but still low: the slave is stretching
  assign freeze = active && (q_q != 2'd0) && !scl_oe && !scl_i;
`else
  assign freeze = 1'b0;
`endif

  i2c_tick_gen #(.W(CLK_DIV_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr    (launch),
    .en     (active),
    .freeze (freeze),
    .div    (clk_div),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (launch) state_d = START;
        START:    if (phase_end) state_d = ADDR;
        ADDR:     if (phase_end && bit_q == 3'd0) state_d = ADDR_ACK;
        ADDR_ACK: if (phase_end) state_d = samp_q ? STOP : DATA;
        DATA:     if (phase_end && bit_q == 3'd0) state_d = DATA_ACK;
        DATA_ACK: if (phase_end) state_d = STOP;
        STOP:     if (phase_end) state_d = DONE;
        DONE:     state_d = IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= 2'd0;
      bit_q   <= 3'd7;
      shift_q <= 8'h00;
      tx_q    <= 8'h00;
      rw_q    <= 1'b0;
      go_q    <= 1'b0;
      samp_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nack_q  <= 1'b0;
      rx      <= 8'h00;
    end else begin
      go_q <= ctrl[CTRL_GO];
      if (launch) begin
        q_q     <= 2'd0;
        bit_q   <= 3'd7;
        shift_q <= {SLAVE_ADDRESS, ctrl[CTRL_RW]};
        tx_q    <= tx;
        rw_q    <= ctrl[CTRL_RW];
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
        nack_q  <= 1'b0;
      end else if (abort) begin
        busy_q <= 1'b0;
        done_q <= 1'b0;
      end else if (tick) begin
        q_q <= q_q + 2'd1;
        if (q_q == 2'd1) samp_q <= sda_i;
        if (q_q == 2'd3) begin
          // bit counter wraps 0 -> 7, ready for the data byte
          case (state_q)
            ADDR, DATA: begin
              shift_q <= {shift_q[6:0], samp_q};
              bit_q   <= bit_q - 3'd1;
            end
            ADDR_ACK: begin
              if (samp_q) nack_q  <= 1'b1;
              else        shift_q <= tx_q;
            end
            DATA_ACK: begin
              if (rw_q)        rx     <= shift_q;
              else if (samp_q) nack_q <= 1'b1;
            end
            STOP: begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_q)
      START: begin
        scl_oe = (q_q == 2'd3);
        sda_oe = (q_q != 2'd0);
      end
      ADDR: begin
        scl_oe = (q_q == 2'd0);
        sda_oe = ~shift_q[7];
      end
      DATA: begin
        scl_oe = (q_q == 2'd0);
        sda_oe = ~rw_q & ~shift_q[7];
      end
      ADDR_ACK, DATA_ACK: scl_oe = (q_q == 2'd0);
      STOP: begin
        scl_oe = (q_q == 2'd0);
        sda_oe = (q_q != 2'd3);
      end
      default: ;
    endcase
  end

  always_comb begin
    status          = 8'h00;
    status[ST_BUSY] = busy_q;
    status[ST_DONE] = done_q;
    status[ST_NACK] = nack_q;
  end

  assign state_debug       = state_q;
  assign bit_counter_debug = bit_q;

endmodule
